// File: rtl/calc2_pkg.sv
// Shared constants and types for the streaming six-operand calculator.
package calc2_pkg;

  localparam int NUM_OPS_DEF = 6;
  localparam int DATA_W_DEF  = 6;
  localparam int OUT_W_DEF   = 10;

  localparam logic [1:0] MODE_SUM  = 2'b00;
  localparam logic [1:0] MODE_MAX  = 2'b01;
  localparam logic [1:0] MODE_MIN  = 2'b10;
  localparam logic [1:0] MODE_TRIM = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/calc2_acc_step.sv
// Combinational next value of the running sum/max/min for one operand;
// the first beat of a frame loads all three from the operand.
module calc2_acc_step import calc2_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic              first_i,
  input  logic [DATA_W-1:0] n_i,
  input  logic [OUT_W-1:0]  sum_i,
  input  logic [DATA_W-1:0] max_i,
  input  logic [DATA_W-1:0] min_i,
  output logic [OUT_W-1:0]  sum_o,
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] min_o
);

  // Load on the first beat, otherwise fold the operand into the running values.
  always_comb begin
    sum_o = sum_i;
    max_o = max_i;
    min_o = min_i;
    if (first_i) begin
      sum_o = OUT_W'(n_i);
      max_o = n_i;
      min_o = n_i;
    end else begin
      sum_o = sum_i + OUT_W'(n_i);
      max_o = (n_i > max_i) ? n_i : max_i;
      min_o = (n_i < min_i) ? n_i : min_i;
    end
  end

endmodule

// File: rtl/calc2_stream.sv
// Handshaked calculator: NUM_OPS operands in, one registered result out.
// Build option CALC2_TRIM_EN enables mode 11 as sum - max - min (else mode 11 = sum).
module calc2_stream import calc2_pkg::*; #(
  parameter int NUM_OPS = NUM_OPS_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] N_IN,
  input  logic [1:0]        MODE,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [OUT_W-1:0]  OUT_N
);

  localparam int CNT_W = $clog2(NUM_OPS + 1);

  state_e             state_q;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   count_q;
  logic [OUT_W-1:0]   sum_q;
  logic [DATA_W-1:0]  max_q;
  logic [DATA_W-1:0]  min_q;
  logic [OUT_W-1:0]   out_n_q;
  logic               out_valid_q;

  logic [OUT_W-1:0]   sum_d;
  logic [DATA_W-1:0]  max_d;
  logic [DATA_W-1:0]  min_d;
  logic [OUT_W-1:0]   result_s;
  logic               accept_s;
  logic               last_s;

  // Ready depends only on state and reset, never on IN_VALID.
  assign IN_READY  = !RST && (state_q != DONE);
  assign accept_s  = IN_VALID && IN_READY;
  assign last_s    = (count_q == CNT_W'(NUM_OPS - 1));
  assign OUT_VALID = out_valid_q;
  assign OUT_N     = out_n_q;

  calc2_acc_step #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_acc_step (
    .first_i (state_q == IDLE),
    .n_i     (N_IN),
    .sum_i   (sum_q),
    .max_i   (max_q),
    .min_i   (min_q),
    .sum_o   (sum_d),
    .max_o   (max_d),
    .min_o   (min_d)
  );

  // Result of the frame using the values that include the final operand.
  always_comb begin
    result_s = sum_d;
    case (mode_q)
      MODE_SUM: result_s = sum_d;
      MODE_MAX: result_s = OUT_W'(max_d);
      MODE_MIN: result_s = OUT_W'(min_d);
`ifdef CALC2_TRIM_EN
      MODE_TRIM: result_s = sum_d - OUT_W'(max_d) - OUT_W'(min_d);
`endif
      default:  result_s = sum_d;
    endcase
  end

  // Frame FSM, operand counter, accumulators and output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      mode_q      <= MODE_SUM;
      count_q     <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      out_n_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            mode_q  <= MODE;
            sum_q   <= sum_d;
            max_q   <= max_d;
            min_q   <= min_d;
            count_q <= CNT_W'(1);
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            sum_q   <= sum_d;
            max_q   <= max_d;
            min_q   <= min_d;
            count_q <= count_q + CNT_W'(1);
            if (last_s) begin
              out_n_q     <= result_s;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc2_stream.sv
// Directed, table-driven bench for calc2_stream plus hand-written corner sequences.
module tb_calc2_stream;

`ifdef CALC2_TRIM_EN
  localparam bit TRIM = 1'b1;
`else
  localparam bit TRIM = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [5:0] N_IN;
  logic [1:0] MODE;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [9:0] OUT_N;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  mode;
    logic [35:0] ops;
    logic [9:0]  exp;
  } vec_t;

  vec_t vecs [8];

  always #5 CLK = ~CLK;

  calc2_stream dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .N_IN      (N_IN),
    .MODE      (MODE),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_N     (OUT_N)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_beat(input logic [5:0] d, input logic [1:0] m);
    int n;
    n = 0;
    IN_VALID = 1'b1;
    N_IN     = d;
    MODE     = m;
    while (!IN_READY && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("beat_timeout", 32'd0, 32'd1);
    tick();
    IN_VALID = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b00, {6'd0, 6'd5, 6'd6, 6'd25, 6'd27, 6'd33}, 10'd96};
    vecs[1] = '{2'b01, {6'd0, 6'd5, 6'd6, 6'd25, 6'd27, 6'd33}, 10'd33};
    vecs[2] = '{2'b10, {6'd0, 6'd5, 6'd6, 6'd25, 6'd27, 6'd33}, 10'd0};
    vecs[3] = '{2'b11, {6'd0, 6'd5, 6'd6, 6'd25, 6'd27, 6'd33}, (TRIM ? 10'd63 : 10'd96)};
    vecs[4] = '{2'b00, {6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63}, 10'd378};
    vecs[5] = '{2'b11, {6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63}, (TRIM ? 10'd252 : 10'd378)};
    vecs[6] = '{2'b10, {6'd10, 6'd11, 6'd12, 6'd8, 6'd9, 6'd7}, 10'd7};
    vecs[7] = '{2'b11, {6'd5, 6'd5, 6'd5, 6'd5, 6'd5, 6'd5}, (TRIM ? 10'd20 : 10'd30)};

    RST = 1'b1; IN_VALID = 1'b0; N_IN = 6'd0; MODE = 2'b00; OUT_READY = 1'b0;
    tick();
    tick();
    check("ready_in_reset", {31'd0, IN_READY}, 32'd0);
    RST = 1'b0;
    #1;
    check("reset_in_ready", {31'd0, IN_READY}, 32'd1);
    check("reset_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("reset_out_n", {22'd0, OUT_N}, 32'd0);

    // Table: OUT_READY tied high, minimum frame period.
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 6; k++) send_beat(vecs[i].ops[6*k +: 6], vecs[i].mode);
      check($sformatf("vec%0d_valid", i), {31'd0, OUT_VALID}, 32'd1);
      check($sformatf("vec%0d_out_n", i), {22'd0, OUT_N}, {22'd0, vecs[i].exp});
      check($sformatf("vec%0d_ready_done", i), {31'd0, IN_READY}, 32'd0);
      tick();
      check($sformatf("vec%0d_valid_drop", i), {31'd0, OUT_VALID}, 32'd0);
      check($sformatf("vec%0d_ready_back", i), {31'd0, IN_READY}, 32'd1);
      check($sformatf("vec%0d_out_hold", i), {22'd0, OUT_N}, {22'd0, vecs[i].exp});
    end

    // Back-pressure: result held three cycles, handshake on the fourth.
    OUT_READY = 1'b0;
    for (int k = 0; k < 6; k++) send_beat(vecs[0].ops[6*k +: 6], 2'b00);
    for (int c = 0; c < 3; c++) begin
      IN_VALID = 1'b1;
      N_IN     = 6'd63;
      check($sformatf("stall%0d_valid", c), {31'd0, OUT_VALID}, 32'd1);
      check($sformatf("stall%0d_out_n", c), {22'd0, OUT_N}, 32'd96);
      check($sformatf("stall%0d_ready", c), {31'd0, IN_READY}, 32'd0);
      tick();
    end
    IN_VALID = 1'b0;
    check("stall3_valid", {31'd0, OUT_VALID}, 32'd1);
    OUT_READY = 1'b1;
    tick();
    check("stall_valid_drop", {31'd0, OUT_VALID}, 32'd0);
    check("stall_ready_back", {31'd0, IN_READY}, 32'd1);
    check("stall_out_hold", {22'd0, OUT_N}, 32'd96);

    // MODE changes after the first beat are ignored; IN_VALID gaps stall.
    send_beat(6'd33, 2'b00);
    for (int k = 1; k < 6; k++) begin
      tick();
      tick();
      send_beat(vecs[0].ops[6*k +: 6], 2'b01);
    end
    check("mode_latch_valid", {31'd0, OUT_VALID}, 32'd1);
    check("mode_latch_out_n", {22'd0, OUT_N}, 32'd96);
    tick();

    // Reset mid-frame discards the partial frame.
    send_beat(6'd63, 2'b01);
    send_beat(6'd63, 2'b01);
    send_beat(6'd63, 2'b01);
    RST = 1'b1;
    #1;
    check("rst_ready_low", {31'd0, IN_READY}, 32'd0);
    tick();
    RST = 1'b0;
    #1;
    check("rst_out_n_clr", {22'd0, OUT_N}, 32'd0);
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_ready_back", {31'd0, IN_READY}, 32'd1);
    for (int k = 1; k <= 6; k++) send_beat(6'(k), 2'b00);
    check("post_rst_valid", {31'd0, OUT_VALID}, 32'd1);
    check("post_rst_out_n", {22'd0, OUT_N}, 32'd21);
    tick();
    check("post_rst_drop", {31'd0, OUT_VALID}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
